// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared defaults and helpers for param_sync_fifo and its interface.
//   DEF_*          : default parameter values (32-bit data, 8 entries,
//                    almost_full at >= 6, almost_empty at <= 1)
//   count_width()  : width of an occupancy counter that must hold 0..DEPTH
//   hs_t           : bundle of the four registered handshake pulses
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_AF_THRESH  = 6;
  localparam int DEF_AE_THRESH  = 1;

  // One extra bit over the address so a completely full FIFO (DEPTH) fits.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  typedef struct packed {
    logic wr_ack;
    logic wr_err;
    logic rd_ack;
    logic rd_err;
  } hs_t;

endpackage

// File: rtl/param_sync_fifo_if.sv
// -----------------------------------------------------------------------------
// param_sync_fifo_if
// Producer/consumer bus of param_sync_fifo.
//   master : drives clr, wr_en, d_in, rd_en; observes data and status
//   slave  : the FIFO side (inverse directions)
// Status: data_count, full, empty, almost_full, almost_empty,
//         wr_ack/wr_err/rd_ack/rd_err (one-cycle registered pulses).
// -----------------------------------------------------------------------------
interface param_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  localparam int CW = count_width(ADDR_WIDTH);

  logic                  clr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] d_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] d_out;
  logic [CW-1:0]         data_count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;

  modport master (
    output clr, wr_en, d_in, rd_en,
    input  d_out, data_count, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err
  );

  modport slave (
    input  clr, wr_en, d_in, rd_en,
    output d_out, data_count, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err
  );

endinterface

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_WIDTH storage array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : mem[i_raddr], combinational
// -----------------------------------------------------------------------------
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read sees the pre-edge contents, so a read and a write of the same
  // slot in one cycle (full FIFO, read+write) returns the old word.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
// Parametrised single-clock FIFO with programmable almost flags, synchronous
// clear and registered ack/err handshake pulses.
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-high reset (priority over clr)
//   bus   : param_sync_fifo_if.slave (clr, wr_en, d_in, rd_en, d_out,
//           data_count, full, empty, almost_full, almost_empty,
//           wr_ack, wr_err, rd_ack, rd_err)
// Build option:
//   FIFO_FWFT_EN defined   : first-word-fall-through; d_out shows the head
//                            word combinationally (0 while empty).
//   FIFO_FWFT_EN undefined : d_out is registered, loaded on an accepted read.
// -----------------------------------------------------------------------------
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic             clk,
  input  logic             reset,
  param_sync_fifo_if.slave bus
);

  localparam int             DEPTH   = 2 ** ADDR_WIDTH;
  localparam int             CW      = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0]  AE_C    = CW'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  hs_t                   r_hs;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_mem_we;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // A write into a full FIFO is still accepted when a read frees a slot in
  // the same cycle; a read of an empty FIFO is never accepted, so there is
  // no write-through path.
  assign w_rd_acc = bus.rd_en && !w_empty;
  assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc);
  assign w_mem_we = w_wr_acc && !bus.clr;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.d_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hs     <= '0;
    end else if (bus.clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hs     <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      // Simultaneous accepted read and write leave occupancy unchanged.
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - 1'b1;
      r_hs.wr_ack <= w_wr_acc;
      r_hs.wr_err <= bus.wr_en && !w_wr_acc;
      r_hs.rd_ack <= w_rd_acc;
      r_hs.rd_err <= bus.rd_en && !w_rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; a pop advances rd_ptr so the next word
  // appears the cycle after the pop.
  assign bus.d_out = w_empty ? '0 : w_head;
`else
  logic [DATA_WIDTH-1:0] r_dout;

  // Output register holds its value on rejected reads and through clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
    end else if (!bus.clr && w_rd_acc) begin
      r_dout <= w_head;
    end
  end

  assign bus.d_out = r_dout;
`endif

  assign bus.data_count   = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= AF_C);
  assign bus.almost_empty = (r_count <= AE_C);
  assign bus.wr_ack       = r_hs.wr_ack;
  assign bus.wr_err       = r_hs.wr_err;
  assign bus.rd_ack       = r_hs.rd_ack;
  assign bus.rd_err       = r_hs.rd_err;

endmodule

// File: tb/tb_param_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_sync_fifo
// Table-driven bench for param_sync_fifo (default registered-read build).
// Each table row gives the inputs for one cycle plus the expected occupancy
// and handshake pulses; flags are derived from the expected occupancy.
// Read data is checked through a scoreboard fed by a queue model of the FIFO.
// -----------------------------------------------------------------------------
module tb_param_sync_fifo;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        clr;
    logic [31:0] din;
    int          cnt;
    logic        wa;
    logic        we;
    logic        ra;
    logic        re;
  } vec_t;

  logic clk;
  logic reset;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_if ();

  param_sync_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  vec_t        tbl[$];
  logic [31:0] mdl_q[$];
  logic [31:0] sb_q[$];
  logic [31:0] last_dout = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic wr, input logic rd, input logic clr,
                              input logic [31:0] din, input int cnt,
                              input logic wa, input logic we,
                              input logic ra, input logic re);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.cnt = cnt;
    v.wa = wa; v.we = we; v.ra = ra; v.re = re;
    tbl.push_back(v);
  endfunction

  task automatic chk_status(input int cnt, input logic wa, input logic we,
                            input logic ra, input logic re);
    chk("count",        32'(u_if.data_count),   32'(cnt));
    chk("full",         32'(u_if.full),         32'(cnt == DEPTH));
    chk("empty",        32'(u_if.empty),        32'(cnt == 0));
    chk("almost_full",  32'(u_if.almost_full),  32'(cnt >= AF));
    chk("almost_empty", 32'(u_if.almost_empty), 32'(cnt <= AE));
    chk("wr_ack",       32'(u_if.wr_ack),       32'(wa));
    chk("wr_err",       32'(u_if.wr_err),       32'(we));
    chk("rd_ack",       32'(u_if.rd_ack),       32'(ra));
    chk("rd_err",       32'(u_if.rd_err),       32'(re));
  endtask

  // Drive one cycle of stimulus, advance the model, then check after the edge.
  task automatic apply(input vec_t v, input int idx);
    int   n;
    logic rd_acc;
    logic wr_acc;
    logic [31:0] e;
    @(negedge clk);
    u_if.wr_en = v.wr;
    u_if.rd_en = v.rd;
    u_if.clr   = v.clr;
    u_if.d_in  = v.din;
    n = mdl_q.size();
    if (v.clr) begin
      mdl_q.delete();
    end else begin
      rd_acc = v.rd && (n > 0);
      wr_acc = v.wr && ((n < DEPTH) || rd_acc);
      if (rd_acc) begin
        last_dout = mdl_q.pop_front();
        sb_q.push_back(last_dout);
      end
      if (wr_acc) mdl_q.push_back(v.din);
    end
    @(posedge clk);
    #1;
    $display("vec %0d: wr=%0b rd=%0b clr=%0b din=0x%0h -> count=%0d d_out=0x%0h acks(w%0b/%0b r%0b/%0b)",
             idx, v.wr, v.rd, v.clr, v.din, u_if.data_count, u_if.d_out,
             u_if.wr_ack, u_if.wr_err, u_if.rd_ack, u_if.rd_err);
    chk_status(v.cnt, v.wa, v.we, v.ra, v.re);
    if (v.ra) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_data: got=0x%0h expected=<none queued>", u_if.d_out);
      end else begin
        e = sb_q.pop_front();
        chk("rd_data", u_if.d_out, e);
      end
    end else begin
      chk("dout_hold", u_if.d_out, last_dout);
    end
  endtask

  initial begin
    vec_t v;
    reset      = 1'b1;
    u_if.clr   = 1'b0;
    u_if.wr_en = 1'b0;
    u_if.rd_en = 1'b0;
    u_if.d_in  = '0;

    // Rows: wr rd clr din cnt | wa we ra re
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);                          // read on empty
    for (int i = 1; i <= 8; i++) add(1, 0, 0, i, i, 1, 0, 0, 0);
    add(1, 0, 0, 32'h9, 8, 0, 1, 0, 0);                      // write when full
    add(0, 0, 0, 0, 8, 0, 0, 0, 0);                          // idle: pulses drop
    for (int i = 1; i <= 8; i++) add(0, 1, 0, 0, 8 - i, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);                          // read when empty
    for (int i = 1; i <= 8; i++) add(1, 0, 0, i, i, 1, 0, 0, 0);
    add(1, 1, 0, 32'hA, 8, 1, 0, 1, 0);                      // full + rd + wr
    for (int i = 1; i <= 8; i++) add(0, 1, 0, 0, 8 - i, 0, 0, 1, 0);
    add(1, 1, 0, 32'h55, 1, 1, 0, 0, 1);                     // empty + rd + wr
    add(0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) add(1, 0, 0, 32'h10 + i, i, 1, 0, 0, 0);
    add(1, 0, 1, 32'hFF, 0, 0, 0, 0, 0);                     // clr beats wr_en
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);                          // flushed: read fails

    // Reset state, sampled while reset is still high.
    #11;
    chk_status(0, 0, 0, 0, 0);
    chk("reset_dout", u_if.d_out, 32'h0);
    #1;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset asserted mid-burst: outputs must clear before the next edge.
    for (int i = 1; i <= 3; i++) begin
      v = '{wr: 1, rd: 0, clr: 0, din: 32'h60 + i, cnt: i, wa: 1, we: 0, ra: 0, re: 0};
      apply(v, 100 + i);
    end
    @(negedge clk);
    u_if.wr_en = 1'b1;
    u_if.d_in  = 32'h77;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    $display("async reset mid-burst: count=%0d d_out=0x%0h", u_if.data_count, u_if.d_out);
    chk_status(0, 0, 0, 0, 0);
    chk("async_reset_dout", u_if.d_out, 32'h0);
    mdl_q.delete();
    sb_q.delete();
    last_dout = '0;
    @(negedge clk);
    reset      = 1'b0;
    u_if.wr_en = 1'b0;

    v = '{wr: 1, rd: 0, clr: 0, din: 32'hC3, cnt: 1, wa: 1, we: 0, ra: 0, re: 0};
    apply(v, 200);
    v = '{wr: 0, rd: 1, clr: 0, din: 32'h0, cnt: 0, wa: 0, we: 0, ra: 1, re: 0};
    apply(v, 201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO; next generation of the team's fixed 32x8 synchronous FIFO. Generalises data width and depth, and adds programmable almost-full/almost-empty flags, a synchronous clear, and defined simultaneous read/write at the full and empty boundaries. It sits between producer/consumer blocks on one clock domain and keeps the existing ack/err handshake so current benches can be reused.

Parameters:
DATA_WIDTH, 32, width of d_in/d_out
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 8 entries)
AF_THRESH, 6, almost_full asserted when data_count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 1, almost_empty asserted when data_count <= AE_THRESH; legal range 0..DEPTH-1

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
clr  in  1  synchronous flush; empties the FIFO
wr_en  in  1  write request
d_in  in  DATA_WIDTH  write data
rd_en  in  1  read request
d_out  out  DATA_WIDTH  read data
data_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
full  out  1  data_count == DEPTH
empty  out  1  data_count == 0
almost_full  out  1  data_count >= AF_THRESH
almost_empty  out  1  data_count <= AE_THRESH
wr_ack  out  1  registered pulse: previous-cycle write accepted
wr_err  out  1  registered pulse: previous-cycle write rejected
rd_ack  out  1  registered pulse: previous-cycle read accepted
rd_err  out  1  registered pulse: previous-cycle read rejected

Behaviour:
- Reset (async, any time): wr_ptr=rd_ptr=0, count=0, d_out=0, all ack/err=0; empty=1, almost_empty=1, full=0, almost_full=0. Memory contents not reset. Reset mid-operation discards stored data.
- State: wr_ptr, rd_ptr (ADDR_WIDTH bits, natural wrap DEPTH-1 -> 0), count (ADDR_WIDTH+1 bits). Flags decoded combinationally from count.
- Acceptance evaluated against pre-edge count:
  - write accepted if wr_en && (!full || rd_accepted); read accepted if rd_en && !empty.
  - full + rd_en + wr_en: both accepted, count stays DEPTH; read returns oldest word, new word written into freed slot.
  - empty + rd_en + wr_en: write accepted, read rejected (rd_err=1); count -> 1. No write-through.
  - count: +1 write only, -1 read only, unchanged both/none.
- Accepted write: mem[wr_ptr]<=d_in, wr_ptr+1, wr_ack=1 next cycle. Rejected: no state change, wr_err=1 next cycle.
- Accepted read (default mode): d_out<=mem[rd_ptr] at the same edge, rd_ptr+1, rd_ack=1; read latency 1 cycle. Rejected: d_out holds, rd_err=1.
- ack/err are one-cycle pulses; deasserted when no request. wr_ack/wr_err mutually exclusive, same for rd.
- clr (sync) overrides wr_en/rd_en: pointers and count -> 0, ack/err -> 0, d_out holds. reset has priority over clr.

Optional Feature:
FIFO_FWFT_EN: first-word-fall-through. Defined: d_out = mem[rd_ptr] whenever !empty (0 when empty), combinational from head; rd_en pops head, and the next word appears at d_out the cycle after the pop; ack/err timing unchanged. Undefined: standard registered read as above.

Decomposition:
- Package fifo_pkg: default DATA_WIDTH/ADDR_WIDTH/threshold constants and a function computing count width.
- Sub-module fifo_mem: DEPTH x DATA_WIDTH register array, one write port, one async read port; control, pointers, flags and handshake stay in param_sync_fifo.

Test Plan:
- reset high 12 ns then low; rd_en=1 on empty -> rd_err pulse, d_out=0, count=0, empty=1.
- write 0x1..0x8 back-to-back -> count 1..8, almost_full at count 6, full at 8; 9th write 0x9 -> wr_err, count stays 8.
- read 8 words -> d_out 0x1..0x8 in order, 1-cycle latency, rd_ack each; almost_empty at count<=1; 9th read -> rd_err.
- full, then rd_en+wr_en with d_in=0xA -> d_out=0x1, count=8, both acks; drain yields 0x2..0x8,0xA (pointer wrap checked).
- empty, rd_en+wr_en with d_in=0x55 -> wr_ack, rd_err, count=1; next read returns 0x55.
- count=5, assert clr with wr_en=1 -> count=0, empty=1, no ack; assert reset mid-burst -> all outputs at reset values immediately, before next clk edge.
